port_resize_stage: RTL and testbench
====================================

Name: port_resize_stage

Overview:
- Parametrised valid/ready pipeline stage that resizes a payload from IN_W to OUT_W bits on its way through a port boundary.
- Resize mode per transaction: sign-extend, zero-extend, truncate, or saturate.
- Two-entry skid buffer, so full throughput is kept under back-pressure.
- Sits between producer and consumer blocks whose port widths and signedness differ. Makes port-width adaptation explicit and registered, instead of relying on implicit port extension.

Parameters:
- IN_W, default 4: input payload width, >= 1.
- OUT_W, default 8: output payload width, >= 1.
- SATURATE, default 1: when OUT_W < IN_W, 1 = clamp to the output range, 0 = keep the low OUT_W bits. Ignored when OUT_W >= IN_W.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  producer has data.
- in_ready  output  1  stage can accept; registered.
- in_data  input  IN_W  payload.
- in_signed  input  1  1 = treat in_data as two's complement; 0 = unsigned. Sampled with in_data.
- out_valid  output  1  stage holds data.
- out_ready  input  1  consumer accepts.
- out_data  output  OUT_W  resized payload.
- out_sat  output  1  this output word was clamped.
- sat_count  output  16  number of clamped words accepted (see Optional Feature).

Behaviour:
- Reset (rst=1 at a clock edge):
  - buffer emptied; out_valid=0, out_data=0, out_sat=0, in_ready=1, sat_count=0.
  - Reset wins over any simultaneous handshake.
  - Data in flight is discarded; no partial word is emitted afterwards.
- Handshakes:
  - Input transfer when in_valid && in_ready. Output transfer when out_valid && out_ready.
  - in_ready = (occupancy < 2), from registered occupancy. It never depends combinationally on out_ready.
  - out_valid = (occupancy > 0).
  - out_data/out_sat stay stable while out_valid && !out_ready.
- Latency: a word accepted at edge N appears on out_data after edge N (visible in cycle N+1). Zero bubbles at full throughput.
- Occupancy 0..2; FIFO order preserved.
  - Simultaneous push and pop at occupancy 1: occupancy stays 1.
  - Pop at occupancy 2 without push: occupancy becomes 1 and in_ready rises next cycle.
  - Push is impossible at occupancy 2.
- Resize, computed combinationally at the input and stored already resized:
  - OUT_W >= IN_W, in_signed=1: sign-extend, replicating in_data[IN_W-1]. out_sat=0.
  - OUT_W >= IN_W, in_signed=0: zero-extend. out_sat=0.
  - OUT_W < IN_W, SATURATE=0: low OUT_W bits. out_sat=0.
  - OUT_W < IN_W, SATURATE=1, signed: clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. out_sat=1 iff the discarded high bits are not all equal to the new MSB.
  - OUT_W < IN_W, SATURATE=1, unsigned: clamp to 2^OUT_W-1. out_sat=1 iff any discarded bit is 1.
- Storage state per entry: {data[OUT_W], sat}. Explicit read/write pointers, or a head/tail pair with a shift on pop.

Optional Feature:
- Macro: PORT_RESIZE_STATS_EN
- Defined:
  - sat_count increments by 1 on each input transfer whose resized word has sat=1.
  - It saturates at 16'hffff and does not wrap.
  - It is cleared only by rst.
- Not defined: sat_count is tied to 0, no counter register is built, and all other behaviour is identical.

Test Plan:
- IN_W=4, OUT_W=8, out_ready=1. Push 4'hd with in_signed=1, then 4'hd with in_signed=0 -> out_data 8'hfd then 8'h0d on consecutive cycles, out_sat=0 for both.
- IN_W=8, OUT_W=4, SATURATE=1. Push signed 8'h7f, 8'hfd, 8'h80, then unsigned 8'h20 -> out_data 4'h7/sat=1, 4'hd/sat=0, 4'h8/sat=1, 4'hf/sat=1. With PORT_RESIZE_STATS_EN, sat_count=3.
- Same push sequence with SATURATE=0 -> out_data 4'hf, 4'hd, 4'h0, 4'h0, all with sat=0.
- Back-pressure: out_ready=0, push 3 words A,B,C back to back -> in_ready low after A and B are accepted, C is held by the producer. Then raise out_ready -> A, B, C delivered in order with no loss or duplication.
- Streaming: in_valid=1 and out_ready=1 for 10 cycles -> 10 words out, one per cycle, occupancy never exceeds 1.
- Reset mid-operation: occupancy 2, assert rst for one cycle -> next cycle out_valid=0, in_ready=1, sat_count=0. The next pushed word is the first word out.

Source files
------------

// File: rtl/port_resize_stage.sv
// port_resize_stage: valid/ready stage that resizes an IN_W payload to OUT_W bits.
// Each word is resized as it is accepted (sign/zero extend, truncate or clamp)
// and held in a two-entry skid buffer, so full throughput is kept under back-pressure.
// Optional build macro: PORT_RESIZE_STATS_EN adds a saturating 16-bit count of
// clamped words; without it sat_count is tied to zero and no counter is built.
module port_resize_stage #(
  parameter int IN_W     = 4,
  parameter int OUT_W    = 8,
  parameter int SATURATE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_sat,
  output logic [15:0]      sat_count
);

  // One extra bit above the wider side keeps every intermediate value exact.
  localparam int XW = ((IN_W > OUT_W) ? IN_W : OUT_W) + 1;

  // Extends the input to XW bits according to its signedness.
  function automatic logic signed [XW-1:0] extend_f(input logic [IN_W-1:0] d,
                                                    input logic sgn);
    logic signed [XW-1:0] x;
    if (sgn) x = {{(XW-IN_W){d[IN_W-1]}}, d};
    else     x = {{(XW-IN_W){1'b0}}, d};
    return x;
  endfunction

  // Produces {sat, data}: low OUT_W bits, or the clamped range limit when the
  // value does not fit and saturation applies to a narrowing resize.
  function automatic logic [OUT_W:0] saturate_f(input logic signed [XW-1:0] x,
                                                input logic sgn);
    logic signed [XW-1:0] umax;
    logic signed [XW-1:0] smax;
    logic signed [XW-1:0] smin;
    logic [OUT_W-1:0]     q;
    logic                 s;
    umax = {{(XW-OUT_W){1'b0}}, {OUT_W{1'b1}}};
    smax = umax >>> 1;
    smin = ~smax;
    q    = x[OUT_W-1:0];
    s    = 1'b0;
    if ((OUT_W < IN_W) && (SATURATE != 0)) begin
      if (sgn) begin
        if (x > smax) begin
          q = smax[OUT_W-1:0];
          s = 1'b1;
        end else if (x < smin) begin
          q = smin[OUT_W-1:0];
          s = 1'b1;
        end
      end else if (x > umax) begin
        q = umax[OUT_W-1:0];
        s = 1'b1;
      end
    end
    return {s, q};
  endfunction

  // ---- stage p0: handshake decode and resize at the input ----
  logic             w_push;
  logic             w_pop;
  logic             w_vld_p1;
  logic [OUT_W:0]   w_res_p0;
  logic [1:0]       w_cnt_nxt;

  // ---- stage p1: two-entry buffer holding resized words ----
  logic [OUT_W-1:0] r_data_p1 [2];
  logic [1:0]       r_sat_p1;
  logic [1:0]       r_cnt_p1;
  logic             r_wr_p1;
  logic             r_rd_p1;
  logic             r_rdy_p1;

  assign w_res_p0 = saturate_f(extend_f(in_data, in_signed), in_signed);
  assign w_vld_p1 = (r_cnt_p1 != 2'd0);
  assign w_push   = in_valid && r_rdy_p1;
  assign w_pop    = w_vld_p1 && out_ready;

  always_comb begin
    w_cnt_nxt = r_cnt_p1;
    case ({w_push, w_pop})
      2'b10:   w_cnt_nxt = r_cnt_p1 + 2'd1;
      2'b01:   w_cnt_nxt = r_cnt_p1 - 2'd1;
      default: w_cnt_nxt = r_cnt_p1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt_p1 <= 2'd0;
      r_wr_p1  <= 1'b0;
      r_rd_p1  <= 1'b0;
      r_rdy_p1 <= 1'b1;
    end else begin
      if (w_push) r_wr_p1 <= ~r_wr_p1;
      if (w_pop)  r_rd_p1 <= ~r_rd_p1;
      r_cnt_p1 <= w_cnt_nxt;
      r_rdy_p1 <= (w_cnt_nxt < 2'd2);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_data_p1[r_wr_p1] <= w_res_p0[OUT_W-1:0];
      r_sat_p1[r_wr_p1]  <= w_res_p0[OUT_W];
    end
  end

  // Payload is forced to zero whenever the buffer is empty, so the data
  // storage itself needs no reset.
  assign in_ready  = r_rdy_p1;
  assign out_valid = w_vld_p1;
  assign out_data  = w_vld_p1 ? r_data_p1[r_rd_p1] : '0;
  assign out_sat   = w_vld_p1 ? r_sat_p1[r_rd_p1] : 1'b0;

`ifdef PORT_RESIZE_STATS_EN
  logic [15:0] r_satcnt_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_satcnt_p1 <= 16'd0;
    end else if (w_push && w_res_p0[OUT_W] && (r_satcnt_p1 != 16'hffff)) begin
      r_satcnt_p1 <= r_satcnt_p1 + 16'd1;
    end
  end

  assign sat_count = r_satcnt_p1;
`else
  assign sat_count = 16'd0;
`endif

endmodule

// File: tb/tb_port_resize_stage.sv
// tb_port_resize_stage: three configurations (4->8, 8->4 clamp, 8->4 truncate)
// driven in lockstep; expected words come from an integer-arithmetic model.
module tb_port_resize_stage;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_signed;
  logic       out_ready;
  logic [7:0] din;

  logic       a_ir, a_ov, a_os;
  logic [7:0] a_od;
  logic [15:0] a_sc;
  logic       b_ir, b_ov, b_os;
  logic [3:0] b_od;
  logic [15:0] b_sc;
  logic       c_ir, c_ov, c_os;
  logic [3:0] c_od;
  logic [15:0] c_sc;

  port_resize_stage #(.IN_W(4), .OUT_W(8), .SATURATE(1)) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_ir), .in_data(din[3:0]),
    .in_signed(in_signed), .out_valid(a_ov), .out_ready(out_ready), .out_data(a_od),
    .out_sat(a_os), .sat_count(a_sc));

  port_resize_stage #(.IN_W(8), .OUT_W(4), .SATURATE(1)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_ir), .in_data(din),
    .in_signed(in_signed), .out_valid(b_ov), .out_ready(out_ready), .out_data(b_od),
    .out_sat(b_os), .sat_count(b_sc));

  port_resize_stage #(.IN_W(8), .OUT_W(4), .SATURATE(0)) u_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c_ir), .in_data(din),
    .in_signed(in_signed), .out_valid(c_ov), .out_ready(out_ready), .out_data(c_od),
    .out_sat(c_os), .sat_count(c_sc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int IW [3] = '{4, 8, 8};
  int OW [3] = '{8, 4, 4};
  int SP [3] = '{1, 1, 0};

  logic [8:0] q [3][$];
  int         scnt [3];
  int         popcnt [3];
  logic       post_rst [3];
  logic       strm = 1'b0;
  int         maxocc = 0;

  // Reference: value as an integer, clamp to the target range, keep low bits.
  function automatic logic [8:0] model(input int wi, input int wo, input int sat,
                                       input logic [7:0] d, input logic s);
    int v, lo, hi, m;
    logic sf;
    v  = int'(d) & ((1 << wi) - 1);
    if (s && v >= (1 << (wi - 1))) v = v - (1 << wi);
    sf = 1'b0;
    if (wo < wi && sat != 0) begin
      if (s) begin
        lo = -(1 << (wo - 1));
        hi = (1 << (wo - 1)) - 1;
      end else begin
        lo = 0;
        hi = (1 << wo) - 1;
      end
      if (v > hi) begin
        v = hi; sf = 1'b1;
      end else if (v < lo) begin
        v = lo; sf = 1'b1;
      end
    end
    m = v & ((1 << wo) - 1);
    return {sf, m[7:0]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: sampled mid-cycle, it checks the state seen by the next edge.
  always @(negedge clk) begin
    logic       irv [3];
    logic       ovv [3];
    logic       osv [3];
    logic [7:0] odv [3];
    logic [15:0] scv [3];
    logic [8:0] e;
    int         occ;
    logic [15:0] sce;
    irv = '{a_ir, b_ir, c_ir};
    ovv = '{a_ov, b_ov, c_ov};
    osv = '{a_os, b_os, c_os};
    odv = '{a_od, {4'h0, b_od}, {4'h0, c_od}};
    scv = '{a_sc, b_sc, c_sc};
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        q[k].delete();
        scnt[k]     = 0;
        post_rst[k] = 1'b1;
      end else begin
        occ = q[k].size();
        if (k == 0 && strm && occ > maxocc) maxocc = occ;
        chk($sformatf("in_ready[%0d]", k), 32'(irv[k]), 32'(occ < 2));
        chk($sformatf("out_valid[%0d]", k), 32'(ovv[k]), 32'(occ > 0));
        if (post_rst[k]) begin
          chk($sformatf("rst_out_data[%0d]", k), 32'(odv[k]), 32'd0);
          chk($sformatf("rst_out_sat[%0d]", k), 32'(osv[k]), 32'd0);
          post_rst[k] = 1'b0;
        end
`ifdef PORT_RESIZE_STATS_EN
        sce = 16'(scnt[k]);
`else
        sce = 16'd0;
`endif
        chk($sformatf("sat_count[%0d]", k), 32'(scv[k]), 32'(sce));
        if (ovv[k] && occ > 0) begin
          e = q[k][0];
          chk($sformatf("out_data[%0d]", k), 32'(odv[k]), 32'(e[7:0]));
          chk($sformatf("out_sat[%0d]", k), 32'(osv[k]), 32'(e[8]));
          if (out_ready) begin
            void'(q[k].pop_front());
            popcnt[k]++;
          end
        end
        if (in_valid && irv[k]) begin
          e = model(IW[k], OW[k], SP[k], din, in_signed);
          q[k].push_back(e);
          if (e[8] && scnt[k] < 65535) scnt[k]++;
        end
      end
    end
  end

  // Presents one word and holds it until the stage takes it (bounded wait).
  task automatic send(input logic [7:0] d, input logic s);
    logic acc;
    acc       = 1'b0;
    in_valid  = 1'b1;
    din       = d;
    in_signed = s;
    for (int t = 0; t < 200 && !acc; t++) begin
      @(negedge clk);
      acc = a_ir;
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: got not-accepted expected accepted for %0h", d);
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int  p0;
    logic prod_done;
    logic done;
    for (int k = 0; k < 3; k++) begin
      scnt[k] = 0; popcnt[k] = 0; post_rst[k] = 1'b0;
    end
    rst = 1'b1; in_valid = 1'b0; din = 8'h00; in_signed = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle(2);

    // Extension and narrowing examples.
    send(8'h0d, 1'b1);
    send(8'h0d, 1'b0);
    idle(3);
    send(8'h7f, 1'b1);
    send(8'hfd, 1'b1);
    send(8'h80, 1'b1);
    send(8'h20, 1'b0);
    idle(3);

    // Back-pressure: third word waits until the consumer resumes.
    out_ready = 1'b0;
    fork
      begin
        send(8'ha1, 1'b0);
        send(8'hb2, 1'b1);
        send(8'hc3, 1'b0);
      end
      begin
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    idle(4);

    // Streaming at full rate.
    out_ready = 1'b1;
    p0 = popcnt[0];
    maxocc = 0;
    strm = 1'b1;
    for (int i = 0; i < 10; i++) send(8'(i * 29 + 3), 1'(i & 1));
    idle(2);
    strm = 1'b0;
    chk("stream_words", 32'(popcnt[0] - p0), 32'd10);
    chk("stream_max_occ", 32'(maxocc <= 1), 32'd1);
    idle(2);

    // Reset with a full buffer.
    out_ready = 1'b0;
    send(8'hf0, 1'b1);
    send(8'h99, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    send(8'h5a, 1'b1);
    idle(3);

    // Randomised traffic with random consumer stalls.
    prod_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          idle($urandom_range(0, 2));
          send(8'($urandom), 1'($urandom));
        end
        prod_done = 1'b1;
      end
      begin
        for (int t = 0; t < 5000 && !prod_done; t++) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join

    // Drain.
    out_ready = 1'b1;
    done = 1'b0;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      done = (q[0].size() == 0) && (q[1].size() == 0) && (q[2].size() == 0);
    end
    chk("drain_empty", 32'(done), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
